// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master to one-slave memory arbiter with starvation bound
//
// Merges the instruction (prefetch) and data (load/store) buses onto one
// 16-bit memory bus. Data normally wins; starve_cnt bounds how many data
// grants may pass while an instruction fetch is waiting. Every memory-side
// request signal and every master-side response is a register.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   instr_m_*         - instruction master: addr, access in; data_in, ack out
//   data_m_*          - data master: addr, data_out, wr_en, bytesel, access in;
//                       data_in, ack out
//   q_m_*             - memory slave: addr, data_out, wr_en, bytesel, access
//                       out; data_in, ack in
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  input  logic [18:0] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic [18:0] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    DONE_I,
    DONE_D
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt, starve_cnt_nxt;

  logic [18:0] addr_nxt;
  logic [15:0] dout_nxt;
  logic        access_nxt;
  logic        wr_en_nxt;
  logic [1:0]  bytesel_nxt;
  logic        iack_nxt;
  logic        dack_nxt;
  logic [15:0] idata_nxt;
  logic [15:0] ddata_nxt;

  logic        elig_i;
  logic        elig_d;
  logic        grant_i;
  logic        grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      starve_cnt      <= 4'd0;
      q_m_addr        <= 19'd0;
      q_m_data_out    <= 16'd0;
      q_m_access      <= 1'b0;
      q_m_wr_en       <= 1'b0;
      q_m_bytesel     <= 2'b00;
      instr_m_ack     <= 1'b0;
      data_m_ack      <= 1'b0;
      instr_m_data_in <= 16'd0;
      data_m_data_in  <= 16'd0;
    end else begin
      state           <= state_nxt;
      starve_cnt      <= starve_cnt_nxt;
      q_m_addr        <= addr_nxt;
      q_m_data_out    <= dout_nxt;
      q_m_access      <= access_nxt;
      q_m_wr_en       <= wr_en_nxt;
      q_m_bytesel     <= bytesel_nxt;
      instr_m_ack     <= iack_nxt;
      data_m_ack      <= dack_nxt;
      instr_m_data_in <= idata_nxt;
      data_m_data_in  <= ddata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    addr_nxt       = q_m_addr;
    dout_nxt       = q_m_data_out;
    access_nxt     = q_m_access;
    wr_en_nxt      = q_m_wr_en;
    bytesel_nxt    = q_m_bytesel;
    iack_nxt       = 1'b0;
    dack_nxt       = 1'b0;
    idata_nxt      = instr_m_data_in;
    ddata_nxt      = data_m_data_in;

    // The master acked in this DONE cycle may still hold access high; it
    // must not be regranted before passing through another state.
    elig_i  = instr_m_access && (state != DONE_I);
    elig_d  = data_m_access && (state != DONE_D);
    grant_i = 1'b0;
    grant_d = 1'b0;

    case (state)
      IDLE, DONE_I, DONE_D: begin
        if (elig_i && elig_d) begin
          if (starve_cnt == LIMIT) grant_i = 1'b1;
          else                     grant_d = 1'b1;
        end else if (elig_i) begin
          grant_i = 1'b1;
        end else if (elig_d) begin
          grant_d = 1'b1;
        end

        if (grant_i) begin
          addr_nxt       = instr_m_addr;
          dout_nxt       = 16'd0;
          wr_en_nxt      = 1'b0;
          bytesel_nxt    = 2'b11;
          access_nxt     = 1'b1;
          starve_cnt_nxt = 4'd0;
          state_nxt      = GRANT_I;
        end else if (grant_d) begin
          addr_nxt    = data_m_addr;
          dout_nxt    = data_m_data_out;
          wr_en_nxt   = data_m_wr_en;
          bytesel_nxt = data_m_bytesel;
          access_nxt  = 1'b1;
          // Count only data grants that actually bypass a waiting fetch.
          if (instr_m_access)
            starve_cnt_nxt = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
          else
            starve_cnt_nxt = 4'd0;
          state_nxt   = GRANT_D;
        end else begin
          state_nxt = IDLE;
        end
      end

      GRANT_I: begin
        if (q_m_ack) begin
          idata_nxt  = q_m_data_in;
          iack_nxt   = 1'b1;
          access_nxt = 1'b0;
          state_nxt  = DONE_I;
        end
      end

      GRANT_D: begin
        if (q_m_ack) begin
          ddata_nxt  = q_m_data_in;
          dack_nxt   = 1'b1;
          access_nxt = 1'b0;
          state_nxt  = DONE_D;
        end
      end

      default: begin
        access_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] instr_m_addr;
  logic [15:0] instr_m_data_in;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [18:0] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_ack;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic [18:0] q_m_addr;
  logic [15:0] q_m_data_in;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_m_addr    (instr_m_addr),
    .instr_m_data_in (instr_m_data_in),
    .instr_m_access  (instr_m_access),
    .instr_m_ack     (instr_m_ack),
    .data_m_addr     (data_m_addr),
    .data_m_data_in  (data_m_data_in),
    .data_m_data_out (data_m_data_out),
    .data_m_access   (data_m_access),
    .data_m_ack      (data_m_ack),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_bytesel  (data_m_bytesel),
    .q_m_addr        (q_m_addr),
    .q_m_data_in     (q_m_data_in),
    .q_m_data_out    (q_m_data_out),
    .q_m_access      (q_m_access),
    .q_m_ack         (q_m_ack),
    .q_m_wr_en       (q_m_wr_en),
    .q_m_bytesel     (q_m_bytesel)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_m_addr    = '0;
    instr_m_access  = 1'b0;
    data_m_addr     = '0;
    data_m_data_out = '0;
    data_m_access   = 1'b0;
    data_m_wr_en    = 1'b0;
    data_m_bytesel  = 2'b00;
    q_m_data_in     = '0;
    q_m_ack         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (q_m_access !== 1'b0) begin bad++; $display("FAIL reset_access: got %0h want 0", q_m_access); end
    total++; if (q_m_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %0h want 0", q_m_wr_en); end
    total++; if (q_m_addr !== 19'd0) begin bad++; $display("FAIL reset_addr: got %0h want 0", q_m_addr); end
    total++; if (q_m_data_out !== 16'd0) begin bad++; $display("FAIL reset_data_out: got %0h want 0", q_m_data_out); end
    total++; if (q_m_bytesel !== 2'b00) begin bad++; $display("FAIL reset_bytesel: got %0h want 0", q_m_bytesel); end
    total++; if (instr_m_ack !== 1'b0) begin bad++; $display("FAIL reset_instr_ack: got %0h want 0", instr_m_ack); end
    total++; if (data_m_ack !== 1'b0) begin bad++; $display("FAIL reset_data_ack: got %0h want 0", data_m_ack); end
    total++; if (instr_m_data_in !== 16'd0) begin bad++; $display("FAIL reset_instr_data: got %0h want 0", instr_m_data_in); end
    total++; if (data_m_data_in !== 16'd0) begin bad++; $display("FAIL reset_data_data: got %0h want 0", data_m_data_in); end
  endtask

  task automatic test_single_fetch();
    instr_m_addr   = 19'h00010;
    instr_m_access = 1'b1;
    next_cycle();
    total++; if (q_m_access !== 1'b1) begin bad++; $display("FAIL fetch_access_c1: got %0h want 1", q_m_access); end
    total++; if (q_m_addr !== 19'h00010) begin bad++; $display("FAIL fetch_addr: got %0h want 10", q_m_addr); end
    total++; if (q_m_wr_en !== 1'b0 || q_m_bytesel !== 2'b11 || q_m_data_out !== 16'd0)
      begin bad++; $display("FAIL fetch_ctrl: got wr=%0h bsel=%0h dout=%0h want 0 3 0", q_m_wr_en, q_m_bytesel, q_m_data_out); end
    total++; if (instr_m_ack !== 1'b0) begin bad++; $display("FAIL fetch_early_ack: got %0h want 0", instr_m_ack); end
    q_m_ack     = 1'b1;
    q_m_data_in = 16'hBEEF;
    next_cycle();
    q_m_ack        = 1'b0;
    total++; if (instr_m_ack !== 1'b1 || instr_m_data_in !== 16'hBEEF)
      begin bad++; $display("FAIL fetch_ack_c2: got ack=%0h data=%0h want 1 beef", instr_m_ack, instr_m_data_in); end
    total++; if (q_m_access !== 1'b0 || data_m_ack !== 1'b0)
      begin bad++; $display("FAIL fetch_c2_other: got access=%0h dack=%0h want 0 0", q_m_access, data_m_ack); end
    instr_m_access = 1'b0;
    next_cycle();
    total++; if (instr_m_ack !== 1'b0 || q_m_access !== 1'b0)
      begin bad++; $display("FAIL fetch_c3: got ack=%0h access=%0h want 0 0", instr_m_ack, q_m_access); end
    total++; if (instr_m_data_in !== 16'hBEEF) begin bad++; $display("FAIL fetch_hold: got %0h want beef", instr_m_data_in); end
  endtask

  task automatic test_data_write();
    int acks;
    data_m_addr     = 19'h01234;
    data_m_data_out = 16'hA55A;
    data_m_bytesel  = 2'b01;
    data_m_wr_en    = 1'b1;
    data_m_access   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      total++;
      if (q_m_access !== 1'b1 || q_m_addr !== 19'h01234 || q_m_data_out !== 16'hA55A ||
          q_m_bytesel !== 2'b01 || q_m_wr_en !== 1'b1 || data_m_ack !== 1'b0)
        begin bad++; $display("FAIL write_stable_c%0d: got acc=%0h addr=%0h dout=%0h bsel=%0h wr=%0h dack=%0h want 1 1234 a55a 1 1 0",
                              i, q_m_access, q_m_addr, q_m_data_out, q_m_bytesel, q_m_wr_en, data_m_ack); end
      if (i == 4) begin
        q_m_ack     = 1'b1;
        q_m_data_in = 16'h1111;
      end
    end
    next_cycle();
    q_m_ack = 1'b0;
    total++; if (data_m_ack !== 1'b1) begin bad++; $display("FAIL write_ack_c5: got %0h want 1", data_m_ack); end
    total++; if (data_m_data_in !== 16'h1111) begin bad++; $display("FAIL write_rdata: got %0h want 1111", data_m_data_in); end
    data_m_access = 1'b0;
    data_m_wr_en  = 1'b0;
    acks = 1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (data_m_ack === 1'b1) acks++;
    end
    total++; if (acks != 1) begin bad++; $display("FAIL write_ack_count: got %0d want 1", acks); end
  endtask

  task automatic test_both_same_cycle();
    data_m_addr    = 19'h00055;
    data_m_wr_en   = 1'b0;
    data_m_bytesel = 2'b11;
    data_m_access  = 1'b1;
    instr_m_addr   = 19'h00777;
    instr_m_access = 1'b1;
    next_cycle();
    total++; if (q_m_access !== 1'b1 || q_m_addr !== 19'h00055)
      begin bad++; $display("FAIL both_first: got acc=%0h addr=%0h want 1 55", q_m_access, q_m_addr); end
    q_m_ack     = 1'b1;
    q_m_data_in = 16'h1234;
    next_cycle();
    q_m_ack       = 1'b0;
    data_m_access = 1'b0;
    total++; if (data_m_ack !== 1'b1 || data_m_data_in !== 16'h1234 || instr_m_ack !== 1'b0)
      begin bad++; $display("FAIL both_dack: got dack=%0h data=%0h iack=%0h want 1 1234 0", data_m_ack, data_m_data_in, instr_m_ack); end
    next_cycle();
    total++; if (q_m_access !== 1'b1 || q_m_addr !== 19'h00777 || q_m_bytesel !== 2'b11)
      begin bad++; $display("FAIL both_second: got acc=%0h addr=%0h bsel=%0h want 1 777 3", q_m_access, q_m_addr, q_m_bytesel); end
    q_m_ack     = 1'b1;
    q_m_data_in = 16'h5678;
    next_cycle();
    q_m_ack        = 1'b0;
    instr_m_access = 1'b0;
    total++; if (instr_m_ack !== 1'b1 || instr_m_data_in !== 16'h5678)
      begin bad++; $display("FAIL both_iack: got ack=%0h data=%0h want 1 5678", instr_m_ack, instr_m_data_in); end
    next_cycle();
  endtask

  // Both masters request together from an idle bus; the loser withdraws, so
  // every round starts from IDLE with the counter as the only history.
  task automatic test_starvation();
    logic [18:0] d_a;
    logic [18:0] exp_a;
    logic        i_wins;
    for (int n = 0; n < 6; n++) begin
      d_a            = 19'h00100 + 19'(n);
      data_m_addr    = d_a;
      data_m_wr_en   = 1'b0;
      data_m_bytesel = 2'b11;
      data_m_access  = 1'b1;
      instr_m_addr   = 19'h00200;
      instr_m_access = 1'b1;
      i_wins         = (n == LIMIT);
      exp_a          = i_wins ? 19'h00200 : d_a;
      next_cycle();
      total++; if (q_m_access !== 1'b1 || q_m_addr !== exp_a)
        begin bad++; $display("FAIL starve_grant_%0d: got acc=%0h addr=%0h want 1 %0h", n, q_m_access, q_m_addr, exp_a); end
      if (i_wins) data_m_access = 1'b0;
      else        instr_m_access = 1'b0;
      q_m_ack     = 1'b1;
      q_m_data_in = 16'(n);
      next_cycle();
      q_m_ack = 1'b0;
      total++; if ((i_wins ? instr_m_ack : data_m_ack) !== 1'b1)
        begin bad++; $display("FAIL starve_ack_%0d: got iack=%0h dack=%0h want winner ack", n, instr_m_ack, data_m_ack); end
      instr_m_access = 1'b0;
      data_m_access  = 1'b0;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    data_m_addr     = 19'h0ABCD;
    data_m_data_out = 16'h1357;
    data_m_bytesel  = 2'b10;
    data_m_wr_en    = 1'b1;
    data_m_access   = 1'b1;
    next_cycle();
    total++; if (q_m_access !== 1'b1) begin bad++; $display("FAIL midrst_granted: got %0h want 1", q_m_access); end
    reset         = 1'b1;
    data_m_access = 1'b0;
    data_m_wr_en  = 1'b0;
    next_cycle();
    reset = 1'b0;
    total++; if (q_m_access !== 1'b0 || instr_m_ack !== 1'b0 || data_m_ack !== 1'b0)
      begin bad++; $display("FAIL midrst_drop: got acc=%0h iack=%0h dack=%0h want 0 0 0", q_m_access, instr_m_ack, data_m_ack); end
    total++; if (q_m_addr !== 19'd0 || data_m_data_in !== 16'd0 || instr_m_data_in !== 16'd0)
      begin bad++; $display("FAIL midrst_regs: got addr=%0h dd=%0h id=%0h want 0 0 0", q_m_addr, data_m_data_in, instr_m_data_in); end
    next_cycle();
    total++; if (q_m_access !== 1'b0 || instr_m_ack !== 1'b0 || data_m_ack !== 1'b0)
      begin bad++; $display("FAIL midrst_idle: got acc=%0h iack=%0h dack=%0h want 0 0 0", q_m_access, instr_m_ack, data_m_ack); end
    instr_m_addr   = 19'h00042;
    instr_m_access = 1'b1;
    next_cycle();
    total++; if (q_m_access !== 1'b1 || q_m_addr !== 19'h00042)
      begin bad++; $display("FAIL midrst_fetch: got acc=%0h addr=%0h want 1 42", q_m_access, q_m_addr); end
    q_m_ack     = 1'b1;
    q_m_data_in = 16'hCAFE;
    next_cycle();
    q_m_ack        = 1'b0;
    instr_m_access = 1'b0;
    total++; if (instr_m_ack !== 1'b1 || instr_m_data_in !== 16'hCAFE)
      begin bad++; $display("FAIL midrst_fetch_ack: got ack=%0h data=%0h want 1 cafe", instr_m_ack, instr_m_data_in); end
    next_cycle();
  endtask

  task automatic test_spurious_ack();
    q_m_ack     = 1'b1;
    q_m_data_in = 16'hDEAD;
    next_cycle();
    q_m_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (q_m_access !== 1'b0 || instr_m_ack !== 1'b0 || data_m_ack !== 1'b0 ||
          instr_m_data_in !== 16'hCAFE || data_m_data_in !== 16'd0 || q_m_addr !== 19'h00042)
        begin bad++; $display("FAIL spurious_%0d: got acc=%0h iack=%0h dack=%0h id=%0h dd=%0h addr=%0h want 0 0 0 cafe 0 42",
                              i, q_m_access, instr_m_ack, data_m_ack, instr_m_data_in, data_m_data_in, q_m_addr); end
      next_cycle();
    end
  endtask

  // Random masters and a random-wait slave, checked every cycle against a
  // transaction-level model of the arbitration rules.
  task automatic test_random(input int ncyc);
    int          owner;          // 0 none, 1 instruction, 2 data
    int          starve;
    int          s_wait;
    logic        e_acc, e_iack, e_dack, e_wr;
    logic [18:0] e_addr;
    logic [15:0] e_dout, e_idata, e_ddata;
    logic [1:0]  e_bsel;
    logic        prev_iack, prev_dack, el_i, el_d;
    logic        n_iack, n_dack;
    int          win;
    int          served;
    do_reset();
    owner = 0; starve = 0; s_wait = 0; served = 0;
    e_acc = 0; e_iack = 0; e_dack = 0; e_wr = 0;
    e_addr = '0; e_dout = '0; e_idata = '0; e_ddata = '0; e_bsel = '0;
    prev_iack = 0; prev_dack = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) next_cycle();
      total++; if (q_m_access !== e_acc) begin bad++; $display("FAIL rnd_access c%0d: got %0h want %0h", c, q_m_access, e_acc); end
      total++; if (instr_m_ack !== e_iack || data_m_ack !== e_dack)
        begin bad++; $display("FAIL rnd_acks c%0d: got i=%0h d=%0h want i=%0h d=%0h", c, instr_m_ack, data_m_ack, e_iack, e_dack); end
      total++;
      if (q_m_addr !== e_addr || q_m_wr_en !== e_wr || q_m_bytesel !== e_bsel || q_m_data_out !== e_dout)
        begin bad++; $display("FAIL rnd_bus c%0d: got addr=%0h wr=%0h bsel=%0h dout=%0h want %0h %0h %0h %0h",
                              c, q_m_addr, q_m_wr_en, q_m_bytesel, q_m_data_out, e_addr, e_wr, e_bsel, e_dout); end
      total++; if (instr_m_data_in !== e_idata || data_m_data_in !== e_ddata)
        begin bad++; $display("FAIL rnd_rdata c%0d: got i=%0h d=%0h want i=%0h d=%0h", c, instr_m_data_in, data_m_data_in, e_idata, e_ddata); end

      // Masters hold a request through their ack cycle, then release it and
      // may start a fresh one.
      if (prev_iack) instr_m_access = 1'b0;
      if (prev_dack) data_m_access  = 1'b0;
      if (!instr_m_access && ($urandom_range(0, 2) == 0)) begin
        instr_m_addr   = 19'($urandom);
        instr_m_access = 1'b1;
      end
      if (!data_m_access && ($urandom_range(0, 2) == 0)) begin
        data_m_addr     = 19'($urandom);
        data_m_data_out = 16'($urandom);
        data_m_wr_en    = 1'($urandom);
        data_m_bytesel  = 2'($urandom);
        data_m_access   = 1'b1;
      end

      q_m_ack = 1'b0;
      if (e_acc) begin
        if (s_wait == 0) begin
          q_m_ack     = 1'b1;
          q_m_data_in = 16'($urandom);
        end else begin
          s_wait--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        q_m_ack     = 1'b1;
        q_m_data_in = 16'($urandom);
      end

      prev_iack = e_iack;
      prev_dack = e_dack;
      n_iack = 1'b0;
      n_dack = 1'b0;
      if (owner != 0) begin
        if (q_m_ack) begin
          if (owner == 1) begin n_iack = 1'b1; e_idata = q_m_data_in; end
          else            begin n_dack = 1'b1; e_ddata = q_m_data_in; end
          owner = 0;
          e_acc = 1'b0;
          served++;
        end
      end else begin
        el_i = instr_m_access && !e_iack;
        el_d = data_m_access && !e_dack;
        if (el_i && el_d) win = (starve == LIMIT) ? 1 : 2;
        else if (el_i)    win = 1;
        else if (el_d)    win = 2;
        else              win = 0;
        if (win == 1) begin
          owner = 1; e_acc = 1'b1;
          e_addr = instr_m_addr; e_wr = 1'b0; e_bsel = 2'b11; e_dout = 16'd0;
          starve = 0;
          s_wait = $urandom_range(0, 3);
        end else if (win == 2) begin
          owner = 2; e_acc = 1'b1;
          e_addr = data_m_addr; e_wr = data_m_wr_en; e_bsel = data_m_bytesel; e_dout = data_m_data_out;
          if (instr_m_access) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
          else                starve = 0;
          s_wait = $urandom_range(0, 3);
        end
      end
      e_iack = n_iack;
      e_dack = n_dack;
    end
    total++; if (served < ncyc / 10) begin bad++; $display("FAIL rnd_throughput: got %0d want >= %0d", served, ncyc / 10); end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_data_write();
    test_both_same_cycle();
    test_starvation();
    test_reset_mid();
    test_spurious_ack();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master to one-slave memory arbiter sitting directly downstream of the core's instruction and data buses. It merges the prefetch (instruction) port and the load/store (data) port onto the single external 16-bit memory bus. Data accesses normally win over instruction fetches, and a starvation counter bounds how long instruction fetches can be locked out. All slave-side request signals and master-side responses are registered, so no combinational path runs from either core port to the memory bus.

## Interface
Parameters:
- STARVE_LIMIT, default 4: consecutive data grants allowed while an instruction request is pending; the next grant then goes to instruction. Legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- instr_m_addr  input  19  instruction word address [19:1]
- instr_m_data_in  output  16  instruction read data; valid only while instr_m_ack=1
- instr_m_access  input  1  instruction request; held high until instr_m_ack
- instr_m_ack  output  1  one-cycle instruction completion
- data_m_addr  input  19  data word address [19:1]
- data_m_data_in  output  16  data read data; valid only while data_m_ack=1
- data_m_data_out  input  16  data write data
- data_m_access  input  1  data request; held high until data_m_ack
- data_m_ack  output  1  one-cycle data completion
- data_m_wr_en  input  1  data write enable
- data_m_bytesel  input  2  data byte lanes
- q_m_addr  output  19  memory address
- q_m_data_in  input  16  memory read data; sampled when q_m_ack=1
- q_m_data_out  output  16  memory write data
- q_m_access  output  1  memory request
- q_m_ack  input  1  memory completion, asserted for exactly one cycle per access
- q_m_wr_en  output  1  memory write enable
- q_m_bytesel  output  2  memory byte lanes

## Operation
- States: IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D.
- Arbitration runs in IDLE, DONE_I and DONE_D.
  - Eligible masters: any whose access is high, excluding the master just completed (the one named by the current DONE state).
  - Both eligible: data wins, unless starve_cnt == STARVE_LIMIT, in which case instruction wins.
  - One eligible: that master wins.
  - None eligible: go to IDLE.
- On a grant, the winning master's addr, wr_en, bytesel and data_out are latched into the q_m_* registers, q_m_access is set to 1, and the state moves to GRANT_x.
- Instruction grants always drive q_m_wr_en=0, q_m_bytesel=2'b11 and q_m_data_out=0.
- GRANT_x: all q_m_* outputs are held stable. On q_m_ack:
  - latch q_m_data_in into the granted master's data_in register;
  - set that master's ack for the following cycle;
  - clear q_m_access;
  - move to DONE_x.
- DONE_x: the master's ack=1 for this single cycle, then arbitration runs as described above.
- starve_cnt (4 bits), updated on each grant:
  - data grant while instr_m_access=1: increment, saturating at STARVE_LIMIT;
  - instruction grant, or data grant with instr_m_access=0: clear to 0.
- A master that drops access while ungranted is simply not served. Dropping access while granted is illegal; the arbiter completes the access anyway and pulses ack.
- The data_in registers hold their last value between acks.

## Timing
- Reset (synchronous) values:
  - state = IDLE, starve_cnt = 0;
  - q_m_access, q_m_wr_en, q_m_addr, q_m_data_out, q_m_bytesel = 0;
  - instr_m_ack, data_m_ack = 0;
  - instr_m_data_in, data_m_data_in = 0.
- Reset mid-access: q_m_access drops on the next edge and no ack is issued to either master. The memory slave must tolerate a withdrawn request.
- Latency:
  - Request high in IDLE at cycle 0 gives q_m_access=1 in cycle 1.
  - A q_m_ack in cycle k gives master ack and data in cycle k+1.
  - With a zero-wait slave (ack in cycle 1), the master sees ack in cycle 2.
- Back-to-back: if the other master is pending, DONE_x grants it directly, so its q_m_access rises in cycle k+2. The same master cannot be regranted from its own DONE state; its earliest re-request passes through IDLE.
- q_m_access is never high in the DONE or IDLE states.
- At most one master ack is high in any cycle.
- A q_m_ack arriving outside GRANT_x is ignored.

## Test plan
- Single instruction fetch, addr 19'h00010, slave acks in cycle 1 with 16'hBEEF -> q_m_access high cycle 1 only; instr_m_ack=1 and instr_m_data_in=16'hBEEF in cycle 2 only; q_m_wr_en=0, q_m_bytesel=2'b11.
- Data write, addr 19'h01234, data_out 16'hA55A, bytesel 2'b01, 3-cycle slave wait -> q_m_* outputs match and stay stable through all wait cycles; data_m_ack pulses exactly once, one cycle after q_m_ack.
- Both masters request in the same cycle, starve_cnt=0 -> data granted first; instruction granted from DONE_D with no IDLE cycle in between.
- Data held continuously pending and instruction pending, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,...; starve_cnt returns to 0 after the instruction grant.
- Reset asserted during GRANT_D with the slave not yet acked -> next cycle q_m_access=0, no ack to either master, state IDLE; a following instruction request is served normally.
- Idle bus with q_m_ack pulsed spuriously -> no master ack; all outputs unchanged.
